// File: rtl/cpu_sram_arbiter.sv
// Round-robin arbiter merging the CPU instruction-fetch and data-access request streams
// onto one single-port memory bus, with one transaction outstanding at a time.
module cpu_sram_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cancel,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        err_timeout
);

    // state  | meaning
    // S_IDLE | no transaction; arbitrate and grant one master
    // S_REQ  | mem_req held with latched fields until mem_addr_ok
    // S_WAIT | request accepted, waiting for mem_data_ok; timeout counter runs
    // S_RESP | owner's data_ok pulse (fetch pulse dropped if cancelled)

    localparam int             CW     = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        state;
    logic          owner_data;
    logic          last_data;
    logic          cancelled;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_wen;
    logic [CW-1:0] wait_cnt;

    logic inst_eligible;
    logic grant_data;
    logic grant_inst;
    logic cancel_hit;

    // A fetch being flushed this cycle is not eligible, so a pending data request wins outright.
    assign inst_eligible = inst_req & ~cancel;
    assign grant_data    = (state == S_IDLE) & data_req & (~inst_eligible | ~last_data);
    assign grant_inst    = (state == S_IDLE) & inst_eligible & ~grant_data;
    assign cancel_hit    = cancel & ~owner_data & (state != S_IDLE);

    assign inst_addr_ok  = grant_inst;
    assign data_addr_ok  = grant_data;

    assign mem_req       = (state == S_REQ);
    assign mem_wr        = |lat_wen;
    assign mem_wstrb     = lat_wen;
    assign mem_addr      = lat_addr;
    assign mem_wdata     = lat_wdata;

    assign inst_data_ok  = (state == S_RESP) & ~owner_data & ~cancelled;
    assign data_data_ok  = (state == S_RESP) & owner_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            owner_data  <= 1'b0;
            last_data   <= 1'b0;
            cancelled   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_wen     <= '0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
            inst_rdata  <= '0;
            data_rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cancelled <= 1'b0;
                    wait_cnt  <= '0;
                    if (grant_data) begin
                        lat_addr   <= data_addr;
                        lat_wdata  <= data_wdata;
                        lat_wen    <= data_wen;
                        owner_data <= 1'b1;
                        last_data  <= 1'b1;
                        state      <= S_REQ;
                    end else if (grant_inst) begin
                        lat_addr   <= inst_addr;
                        lat_wdata  <= '0;
                        lat_wen    <= '0;
                        owner_data <= 1'b0;
                        last_data  <= 1'b0;
                        state      <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (cancel_hit)
                        cancelled <= 1'b1;
                    if (mem_addr_ok) begin
                        if (mem_data_ok) begin
                            if (owner_data)
                                data_rdata <= mem_rdata;
                            else
                                inst_rdata <= mem_rdata;
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (cancel_hit)
                        cancelled <= 1'b1;
                    if (mem_data_ok) begin
                        if (owner_data)
                            data_rdata <= mem_rdata;
                        else
                            inst_rdata <= mem_rdata;
                        state <= S_RESP;
                    end else if (wait_cnt != TO_VAL) begin
                        // Counter saturates at TIMEOUT; the flag stays sticky until reset.
                        wait_cnt <= wait_cnt + CW'(1);
                        if ((wait_cnt + CW'(1)) == TO_VAL)
                            err_timeout <= 1'b1;
                    end
                end

                S_RESP: begin
                    cancelled <= 1'b0;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
